// File: rtl/sram_axi_slave_if.sv
// AXI write/read channel bundle between an AXI master and the SRAM slave.
interface sram_axi_slave_if #(parameter int ID_W = 8);
    logic [ID_W-1:0] AWID;
    logic [31:0]     AWADDR;
    logic [3:0]      AWLEN;
    logic            AWVALID;
    logic            AWREADY;
    logic [31:0]     WDATA;
    logic [3:0]      WSTRB;
    logic            WLAST;
    logic            WVALID;
    logic            WREADY;
    logic [ID_W-1:0] BID;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;
    logic [ID_W-1:0] ARID;
    logic [31:0]     ARADDR;
    logic [3:0]      ARLEN;
    logic            ARVALID;
    logic            ARREADY;
    logic [ID_W-1:0] RID;
    logic [31:0]     RDATA;
    logic [1:0]      RRESP;
    logic            RLAST;
    logic            RVALID;
    logic            RREADY;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
               ARID, ARADDR, ARLEN, ARVALID, RREADY,
        output AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );
    modport master (
        output AWID, AWADDR, AWLEN, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
               ARID, ARADDR, ARLEN, ARVALID, RREADY,
        input  AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/sram_axi_slave.sv
// Single-outstanding AXI slave in front of a 32K x 32 synchronous SRAM (INCR, word size).
// AXI_BURST_EN: when defined AWLEN/ARLEN are honoured, otherwise every transfer is one beat.
module sram_axi_slave #(
    parameter int ID_W = 8
) (
    input  logic            ACLK,
    input  logic            ARESETn,
    sram_axi_slave_if.slave axi,
    output logic            CS,
    output logic            WE,
    output logic [14:0]     A,
    output logic [3:0]      BYTE,
    output logic [31:0]     DI,
    input  logic [31:0]     DO
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP} state_t;

    state_t          state_q, state_d;
    logic            rdy_q;
    logic [ID_W-1:0] id_q, id_d;
    logic [14:0]     word_q, word_d;
    logic [3:0]      beat_q, beat_d, len_q, len_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rd_first_q, rd_first_d;
    logic [3:0]      aw_len, ar_len;

`ifdef AXI_BURST_EN
    assign aw_len = axi.AWLEN;
    assign ar_len = axi.ARLEN;
`else
    assign aw_len = 4'd0;
    assign ar_len = 4'd0;
    logic unused_len;
    assign unused_len = ^{axi.AWLEN, axi.ARLEN};
`endif

    logic unused_bits;
    assign unused_bits = ^{axi.WLAST, axi.AWADDR[31:17], axi.AWADDR[1:0],
                           axi.ARADDR[31:17], axi.ARADDR[1:0]};

    // rdy_q holds the address channels low until the first edge after reset release
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= IDLE;
            rdy_q      <= 1'b0;
            id_q       <= '0;
            word_q     <= '0;
            beat_q     <= '0;
            len_q      <= '0;
            rdata_q    <= '0;
            rd_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdy_q      <= 1'b1;
            id_q       <= id_d;
            word_q     <= word_d;
            beat_q     <= beat_d;
            len_q      <= len_d;
            rdata_q    <= rdata_d;
            rd_first_q <= rd_first_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        word_d      = word_q;
        beat_d      = beat_q;
        len_d       = len_q;
        rdata_d     = rdata_q;
        rd_first_d  = 1'b0;
        axi.AWREADY = 1'b0;
        axi.ARREADY = 1'b0;
        axi.WREADY  = 1'b0;
        axi.BVALID  = 1'b0;
        axi.BID     = id_q;
        axi.BRESP   = 2'b00;
        axi.RVALID  = 1'b0;
        axi.RLAST   = 1'b0;
        axi.RID     = id_q;
        axi.RRESP   = 2'b00;
        // DO is live only in the first data cycle; afterwards the captured copy is held
        axi.RDATA   = rd_first_q ? DO : rdata_q;
        CS          = 1'b0;
        WE          = 1'b0;
        A           = word_q;
        BYTE        = axi.WSTRB;
        DI          = axi.WDATA;
        case (state_q)
            IDLE: begin
                axi.AWREADY = rdy_q;
                axi.ARREADY = rdy_q & ~axi.AWVALID;
                if (axi.AWVALID && rdy_q) begin
                    id_d    = axi.AWID;
                    word_d  = axi.AWADDR[16:2];
                    beat_d  = 4'd0;
                    len_d   = aw_len;
                    state_d = WR_DATA;
                end else if (axi.ARVALID && rdy_q) begin
                    id_d    = axi.ARID;
                    word_d  = axi.ARADDR[16:2];
                    beat_d  = 4'd0;
                    len_d   = ar_len;
                    state_d = RD_REQ;
                end
            end
            WR_DATA: begin
                axi.WREADY = 1'b1;
                if (axi.WVALID) begin
                    CS     = 1'b1;
                    WE     = 1'b1;
                    word_d = word_q + 15'd1;
                    beat_d = beat_q + 4'd1;
                    if (beat_q == len_q) state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                axi.BVALID = 1'b1;
                if (axi.BREADY) state_d = IDLE;
            end
            RD_REQ: begin
                CS         = 1'b1;
                rd_first_d = 1'b1;
                state_d    = RD_DATA;
            end
            RD_DATA: begin
                axi.RVALID = 1'b1;
                axi.RLAST  = (beat_q == len_q);
                if (rd_first_q) rdata_d = DO;
                if (axi.RREADY) begin
                    if (beat_q == len_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RD_REQ;
                        word_d  = word_q + 15'd1;
                        beat_d  = beat_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sram_axi_slave.sv
// Directed bench: reference memory + expectation queues checked every cycle, plus literal pins.
module tb_sram_axi_slave;
    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        CS, WE;
    logic [14:0] A;
    logic [3:0]  BYTE;
    logic [31:0] DI;
    logic [31:0] DO = '0;

    sram_axi_slave_if #(.ID_W(8)) bus ();

    sram_axi_slave #(.ID_W(8)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .axi(bus),
        .CS(CS), .WE(WE), .A(A), .BYTE(BYTE), .DI(DI), .DO(DO)
    );

    always #5 ACLK = ~ACLK;

    logic [31:0] mem     [0:32767];
    logic [31:0] ref_mem [0:32767];

    // synchronous SRAM: byte-masked write, registered read
    always @(posedge ACLK) begin
        if (CS) begin
            if (WE) begin
                for (int b = 0; b < 4; b++)
                    if (BYTE[b]) mem[A][8*b +: 8] <= DI[8*b +: 8];
            end else begin
                DO <= mem[A];
            end
        end
    end

    typedef struct { bit we; bit [14:0] a; bit [3:0] be; bit [31:0] di; } acc_t;
    typedef struct { bit [7:0] id; bit [31:0] data; bit last; } rexp_t;
    acc_t        acc_q[$];
    rexp_t       r_q[$];
    bit [7:0]    b_q[$];
    bit [14:0]   wa_log[$];
    bit [31:0]   rd_log[$];
    bit          rl_log[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] eff_len(input logic [3:0] len);
`ifdef AXI_BURST_EN
        return len;
`else
        return 4'd0;
`endif
    endfunction

    // per-cycle comparison against the expectation queues
    always @(negedge ACLK) begin
        if (ARESETn) begin
            if (CS) begin
                if (acc_q.size() == 0) check("cs_unexpected", 32'(CS), 32'd0);
                else begin
                    acc_t e;
                    e = acc_q.pop_front();
                    check("sram_we", 32'(WE), 32'(e.we));
                    check("sram_a", 32'(A), 32'(e.a));
                    if (e.we) begin
                        check("sram_byte", 32'(BYTE), 32'(e.be));
                        check("sram_di", DI, e.di);
                        wa_log.push_back(A);
                    end
                end
            end
            if (bus.BVALID) begin
                if (b_q.size() == 0) check("b_unexpected", 32'(bus.BVALID), 32'd0);
                else begin
                    check("bid", 32'(bus.BID), 32'(b_q[0]));
                    check("bresp", 32'(bus.BRESP), 32'd0);
                    if (bus.BREADY) void'(b_q.pop_front());
                end
            end
            if (bus.RVALID) begin
                if (r_q.size() == 0) check("r_unexpected", 32'(bus.RVALID), 32'd0);
                else begin
                    check("rdata", bus.RDATA, r_q[0].data);
                    check("rlast", 32'(bus.RLAST), 32'(r_q[0].last));
                    check("rid", 32'(bus.RID), 32'(r_q[0].id));
                    check("rresp", 32'(bus.RRESP), 32'd0);
                    if (bus.RREADY) begin
                        rd_log.push_back(bus.RDATA);
                        rl_log.push_back(bus.RLAST);
                        void'(r_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic expect_write(input bit [7:0] id, input bit [31:0] addr, input bit [3:0] len,
                                input bit [31:0] d0, input bit [3:0] strb);
        for (int i = 0; i <= int'(eff_len(len)); i++) begin
            acc_t e;
            e.we = 1'b1; e.a = 15'(addr[16:2] + i); e.be = strb; e.di = d0 + i;
            acc_q.push_back(e);
            for (int b = 0; b < 4; b++)
                if (strb[b]) ref_mem[e.a][8*b +: 8] = e.di[8*b +: 8];
        end
        b_q.push_back(id);
    endtask

    task automatic expect_read(input bit [7:0] id, input bit [31:0] addr, input bit [3:0] len);
        for (int i = 0; i <= int'(eff_len(len)); i++) begin
            acc_t e;
            rexp_t r;
            e.we = 1'b0; e.a = 15'(addr[16:2] + i); e.be = 4'd0; e.di = 32'd0;
            acc_q.push_back(e);
            r.id = id; r.data = ref_mem[e.a]; r.last = (i == int'(eff_len(len)));
            r_q.push_back(r);
        end
    endtask

    function automatic logic sig(input int s);
        case (s)
            0: return bus.AWREADY;
            1: return bus.ARREADY;
            2: return bus.WREADY;
            3: return bus.BVALID;
            default: return bus.RVALID;
        endcase
    endfunction

    task automatic wait_sig(input int s, input string nm);
        bit ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge ACLK);
            if (sig(s)) begin ok = 1'b1; break; end
        end
        if (!ok) check({"timeout_", nm}, 32'd0, 32'd1);
    endtask

    task automatic aw_hs(input bit [7:0] id, input bit [31:0] addr, input bit [3:0] len);
        bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWVALID = 1'b1;
        wait_sig(0, "awready");
        @(posedge ACLK); #1 bus.AWVALID = 1'b0;
    endtask

    task automatic ar_hs(input bit [7:0] id, input bit [31:0] addr, input bit [3:0] len);
        bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARVALID = 1'b1;
        wait_sig(1, "arready");
        @(posedge ACLK); #1 bus.ARVALID = 1'b0;
    endtask

    task automatic w_beats(input bit [3:0] len, input bit [31:0] d0, input bit [3:0] strb);
        for (int i = 0; i <= int'(eff_len(len)); i++) begin
            bus.WDATA = d0 + i; bus.WSTRB = strb; bus.WLAST = (i == int'(eff_len(len)));
            bus.WVALID = 1'b1;
            wait_sig(2, "wready");
            @(posedge ACLK); #1;
        end
        bus.WVALID = 1'b0;
    endtask

    task automatic b_hs();
        bus.BREADY = 1'b1;
        wait_sig(3, "bvalid");
        @(posedge ACLK); #1 bus.BREADY = 1'b0;
    endtask

    task automatic r_beats(input bit [3:0] len, input int stall);
        int cnt = 0;
        if (stall > 0) begin
            logic [31:0] d0;
            wait_sig(4, "rvalid");
            d0 = bus.RDATA;
            for (int k = 0; k < stall; k++) begin
                @(negedge ACLK);
                check("stall_rvalid", 32'(bus.RVALID), 32'd1);
                check("stall_rdata", bus.RDATA, d0);
                check("stall_cs", 32'(CS), 32'd0);
            end
            @(posedge ACLK); #1;
        end
        bus.RREADY = 1'b1;
        for (int n = 0; n < 100 && cnt <= int'(eff_len(len)); n++) begin
            @(negedge ACLK);
            if (bus.RVALID) cnt++;
        end
        if (cnt <= int'(eff_len(len))) check("timeout_rbeats", 32'(cnt), 32'(eff_len(len)) + 1);
        @(posedge ACLK); #1 bus.RREADY = 1'b0;
    endtask

    task automatic do_write(input bit [7:0] id, input bit [31:0] addr, input bit [3:0] len,
                            input bit [31:0] d0, input bit [3:0] strb);
        expect_write(id, addr, len, d0, strb);
        aw_hs(id, addr, len);
        w_beats(len, d0, strb);
        b_hs();
    endtask

    task automatic do_read(input bit [7:0] id, input bit [31:0] addr, input bit [3:0] len, input int stall);
        expect_read(id, addr, len);
        ar_hs(id, addr, len);
        r_beats(len, stall);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"}, 32'(bus.AWREADY), 32'd0);
        check({tag, "_arready"}, 32'(bus.ARREADY), 32'd0);
        check({tag, "_wready"},  32'(bus.WREADY), 32'd0);
        check({tag, "_bvalid"},  32'(bus.BVALID), 32'd0);
        check({tag, "_rvalid"},  32'(bus.RVALID), 32'd0);
        check({tag, "_rlast"},   32'(bus.RLAST), 32'd0);
        check({tag, "_cs"},      32'(CS), 32'd0);
        check({tag, "_we"},      32'(WE), 32'd0);
        check({tag, "_bresp"},   32'(bus.BRESP), 32'd0);
        check({tag, "_rresp"},   32'(bus.RRESP), 32'd0);
        check({tag, "_bid"},     32'(bus.BID), 32'd0);
        check({tag, "_rdata"},   bus.RDATA, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32768; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
        bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

        // reset state and first rise of the address readies
        repeat (3) @(negedge ACLK);
        check_reset_outputs("rst");
        #1 ARESETn = 1'b1;
        #1 check("rdy_before_edge", 32'(bus.AWREADY), 32'd0);
        @(negedge ACLK);
        check("awready_after_edge", 32'(bus.AWREADY), 32'd1);
        check("arready_after_edge", 32'(bus.ARREADY), 32'd1);
        @(posedge ACLK); #1;

        // single full-word write
        wa_log.delete();
        do_write(8'h11, 32'h100, 4'd0, 32'hDEADBEEF, 4'hF);
        check("single_wr_beats", 32'(wa_log.size()), 32'd1);
        if (wa_log.size() > 0) check("single_wr_a", 32'(wa_log[0]), 32'h040);

        // byte write merges into the earlier word
        do_write(8'h22, 32'h100, 4'd0, 32'h0000AB00, 4'b0010);
        rd_log.delete(); rl_log.delete();
        do_read(8'h33, 32'h100, 4'd0, 0);
        check("byte_rd_count", 32'(rd_log.size()), 32'd1);
        if (rd_log.size() > 0) begin
            check("byte_rd_data", rd_log[0], 32'hDEADABEF);
            check("byte_rd_last", 32'(rl_log[0]), 32'd1);
        end

        // zero strobe still handshakes, leaves data untouched; ignored address bits
        do_write(8'h44, 32'h104, 4'd0, 32'h12345678, 4'hF);
        do_write(8'h45, 32'h104, 4'd0, 32'hFFFFFFFF, 4'h0);
        do_read(8'h46, 32'h104, 4'd0, 0);
        do_write(8'h47, 32'hFFFE0203, 4'd0, 32'h0BADF00D, 4'hF);
        do_read(8'h48, 32'h200, 4'd0, 0);

        // four-beat burst across the word-counter wrap
        wa_log.delete(); rd_log.delete(); rl_log.delete();
        do_write(8'h55, 32'h1FFF8, 4'd3, 32'd1, 4'hF);
        do_read(8'h66, 32'h1FFF8, 4'd3, 0);
`ifdef AXI_BURST_EN
        check("burst_wr_beats", 32'(wa_log.size()), 32'd4);
        check("burst_rd_beats", 32'(rd_log.size()), 32'd4);
        if (wa_log.size() == 4 && rd_log.size() == 4) begin
            check("burst_a0", 32'(wa_log[0]), 32'h7FFE);
            check("burst_a1", 32'(wa_log[1]), 32'h7FFF);
            check("burst_a2", 32'(wa_log[2]), 32'h0000);
            check("burst_a3", 32'(wa_log[3]), 32'h0001);
            check("burst_d0", rd_log[0], 32'd1);
            check("burst_d3", rd_log[3], 32'd4);
            check("burst_last2", 32'(rl_log[2]), 32'd0);
            check("burst_last3", 32'(rl_log[3]), 32'd1);
        end
`else
        check("single_wr_beats_len3", 32'(wa_log.size()), 32'd1);
        check("single_rd_beats_len3", 32'(rd_log.size()), 32'd1);
        if (wa_log.size() == 1 && rd_log.size() == 1) begin
            check("single_a_len3", 32'(wa_log[0]), 32'h7FFE);
            check("single_d_len3", rd_log[0], 32'd1);
            check("single_last_len3", 32'(rl_log[0]), 32'd1);
        end
`endif

        // read backpressure: data held, no SRAM activity
        do_read(8'h77, 32'h100, 4'd0, 5);

        // simultaneous AW and AR: write wins, read sees the new data
        expect_write(8'h88, 32'h300, 4'd0, 32'hCAFEF00D, 4'hF);
        expect_read(8'h99, 32'h300, 4'd0);
        bus.AWID = 8'h88; bus.AWADDR = 32'h300; bus.AWLEN = 4'd0; bus.AWVALID = 1'b1;
        bus.ARID = 8'h99; bus.ARADDR = 32'h300; bus.ARLEN = 4'd0; bus.ARVALID = 1'b1;
        wait_sig(0, "awready_both");
        check("both_arready_low", 32'(bus.ARREADY), 32'd0);
        @(posedge ACLK); #1 bus.AWVALID = 1'b0;
        @(negedge ACLK);
        check("wr_stall_arready", 32'(bus.ARREADY), 32'd0);
        check("wr_stall_awready", 32'(bus.AWREADY), 32'd0);
        @(posedge ACLK); #1;
        w_beats(4'd0, 32'hCAFEF00D, 4'hF);
        b_hs();
        rd_log.delete();
        wait_sig(1, "arready_after_b");
        @(posedge ACLK); #1 bus.ARVALID = 1'b0;
        r_beats(4'd0, 0);
        if (rd_log.size() > 0) check("both_rd_data", rd_log[0], 32'hCAFEF00D);

        // reset in the middle of a burst
        begin
            acc_t e;
            e.we = 1'b1; e.a = 15'h100; e.be = 4'hF; e.di = 32'hA5A50001;
            acc_q.push_back(e);
            ref_mem[15'h100] = 32'hA5A50001;
            b_q.push_back(8'hAA);
        end
        aw_hs(8'hAA, 32'h400, 4'd3);
        bus.WDATA = 32'hA5A50001; bus.WSTRB = 4'hF; bus.WLAST = 1'b0; bus.WVALID = 1'b1;
        wait_sig(2, "wready_abort");
        @(posedge ACLK); #1 bus.WVALID = 1'b0;
        ARESETn = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge ACLK);
        check("midrst_cs_hold", 32'(CS), 32'd0);
        acc_q.delete(); b_q.delete(); r_q.delete();
        #1 ARESETn = 1'b1;
        #1 check("midrst_rdy_before_edge", 32'(bus.AWREADY), 32'd0);
        @(negedge ACLK);
        check("midrst_awready_back", 32'(bus.AWREADY), 32'd1);
        @(posedge ACLK); #1;
        do_read(8'hBB, 32'h400, 4'd0, 0);
        do_read(8'hBC, 32'h404, 4'd0, 0);
        do_read(8'hBD, 32'h100, 4'd0, 0);

        repeat (3) @(negedge ACLK);
        check("acc_q_drained", 32'(acc_q.size()), 32'd0);
        check("r_q_drained", 32'(r_q.size()), 32'd0);
        check("b_q_drained", 32'(b_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
